// File: rtl/serdes_rx_deframer.sv
// rtl/serdes_rx_deframer.sv - RX byte-stream deframer with commit/rollback payload FIFO
// Optional abort statistics counter enabled by SERDES_DEFRAMER_STATS_EN.
module serdes_rx_deframer #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SOF_BYTE   = 8'hA5,
  parameter int          MAX_LEN    = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  input  logic       errRX,
  input  logic       invalidData,
  input  logic       wrongRD,
  input  logic       rdReq,
  output logic [7:0] fifoData,
  output logic       fifoEmpty,
  output logic       fifoFull,
  output logic       frameDone,
  output logic       frameErr,
  output logic [7:0] errCount
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              PW        = AW + 1;
  localparam logic [PW-1:0]   DEPTH_P   = PW'(FIFO_DEPTH);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_ABORT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr, commit_ptr;
  logic [7:0]    csum, remaining;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          done_q;
  logic          bad, do_read, do_len, do_write, do_commit, do_abort;

  assign bad       = errRX | invalidData | wrongRD;
  assign fifoEmpty = (rd_ptr == commit_ptr);
  // Full counts uncommitted bytes too: they occupy real slots until rollback.
  assign fifoFull  = ((wr_ptr - rd_ptr) == DEPTH_P);
  assign fifoData  = fifoEmpty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign do_read   = rdReq & ~fifoEmpty;
  assign frameDone = done_q;
  assign frameErr  = (state == S_ABORT);

  always_comb begin
    state_nxt = state;
    do_len    = 1'b0;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxValid && !bad && rxData == SOF_BYTE) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (rxValid) begin
          if (bad || rxData == 8'h00 || rxData > MAX_LEN_B) begin
            do_abort = 1'b1;
          end else begin
            do_len    = 1'b1;
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rxValid) begin
          if (bad || fifoFull) begin
            do_abort = 1'b1;
          end else begin
            do_write = 1'b1;
            if (remaining == 8'd1) state_nxt = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rxValid) begin
          if (!bad && rxData == csum) begin
            do_commit = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            do_abort = 1'b1;
          end
        end
      end
      S_ABORT:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (do_abort) state_nxt = S_ABORT;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      csum       <= 8'h00;
      remaining  <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= do_commit;
      if (do_read) rd_ptr <= rd_ptr + 1'b1;
      if (do_len) begin
        remaining <= rxData;
        csum      <= 8'h00;
      end
      if (do_write) begin
        wr_ptr    <= wr_ptr + 1'b1;
        csum      <= csum + rxData;
        remaining <= remaining - 8'd1;
      end
      if (do_abort)  wr_ptr     <= commit_ptr;
      if (do_commit) commit_ptr <= wr_ptr;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && do_write) mem[wr_ptr[AW-1:0]] <= rxData;
  end

`ifdef SERDES_DEFRAMER_STATS_EN
  logic [7:0] err_cnt;
  always_ff @(posedge CLOCK_50) begin
    if (reset)                             err_cnt <= 8'h00;
    else if (do_abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
  assign errCount = err_cnt;
`else
  assign errCount = 8'h00;
`endif

endmodule

// File: tb/tb_serdes_rx_deframer.sv
// tb/tb_serdes_rx_deframer.sv - bench for serdes_rx_deframer, frame-level queue model
module tb_serdes_rx_deframer;

  localparam int         DEPTH = 16;
  localparam int         MAXL  = 16;
  localparam logic [7:0] SOF   = 8'hA5;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       rxValid = 1'b0;
  logic       errRX = 1'b0, invalidData = 1'b0, wrongRD = 1'b0;
  logic       rdReq = 1'b0;
  logic [7:0] fifoData, errCount;
  logic       fifoEmpty, fifoFull, frameDone, frameErr;

  serdes_rx_deframer #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(SOF), .MAX_LEN(MAXL)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .rxData(rxData), .rxValid(rxValid),
    .errRX(errRX), .invalidData(invalidData), .wrongRD(wrongRD), .rdReq(rdReq),
    .fifoData(fifoData), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
    .frameDone(frameDone), .frameErr(frameErr), .errCount(errCount)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int         n_checks = 0;
  int         n_err = 0;
  int         aborts = 0;
  bit         rand_gap = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] tx_b[$];
  logic [2:0] tx_f[$];
  logic [7:0] pay[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ec();
`ifdef SERDES_DEFRAMER_STATS_EN
    return (aborts > 255) ? 32'd255 : 32'(aborts);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic [2:0] f);
    if (rand_gap && ($urandom % 4) == 0) begin
      int g = $urandom_range(1, 3);
      for (int i = 0; i < g; i++) begin
        rxValid = 1'b0;
        rxData = 8'($urandom);
        {errRX, invalidData, wrongRD} = 3'($urandom);
        tick();
      end
    end
    rxData = b;
    {errRX, invalidData, wrongRD} = f;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
    {errRX, invalidData, wrongRD} = 3'b000;
  endtask

  task automatic push_b(input logic [7:0] b, input logic [2:0] f);
    tx_b.push_back(b);
    tx_f.push_back(f);
  endtask

  // csum_mode: 0 no checksum byte, 1 correct checksum, 2 corrupted checksum
  task automatic push_frame(input int len, input int npay, input int csum_mode);
    logic [7:0] sum = 8'h00;
    push_b(SOF, 3'b000);
    push_b(8'(len), 3'b000);
    pay.delete();
    for (int i = 0; i < npay; i++) begin
      logic [7:0] r = 8'($urandom);
      pay.push_back(r);
      sum += r;
      push_b(r, 3'b000);
    end
    if (csum_mode == 1) push_b(sum, 3'b000);
    if (csum_mode == 2) push_b(sum ^ 8'($urandom_range(1, 255)), 3'b000);
  endtask

  // outcome: 0 no pulse, 1 frameDone on last byte, 2 frameErr on last byte
  task automatic xfer(input int outcome, input bit trail);
    for (int i = 0; i < tx_b.size(); i++) begin
      put(tx_b[i], tx_f[i]);
      if (i == tx_b.size() - 1)
        chk("pulse_last", {frameDone, frameErr}, (outcome == 1) ? 2'b10 : (outcome == 2) ? 2'b01 : 2'b00);
      else
        chk("pulse_mid", {frameDone, frameErr}, 2'b00);
    end
    if (outcome == 2) begin
      aborts++;
      chk("err_count", errCount, exp_ec());
    end
    if (outcome == 1) foreach (pay[i]) mq.push_back(pay[i]);
    if (trail) begin
      tick();
      chk("pulse_clear", {frameDone, frameErr}, 2'b00);
    end
    tx_b.delete();
    tx_f.delete();
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      chk("pop_empty", fifoEmpty, 1'b0);
      chk("pop_data", fifoData, mq.pop_front());
      rdReq = 1'b1;
      tick();
      rdReq = 1'b0;
    end
  endtask

  task automatic drain();
    pop_n(mq.size());
    chk("drain_empty", fifoEmpty, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int len, room, j, kind, n;
    logic [7:0] gb;

    // reset state
    do_reset();
    chk("rst_empty", fifoEmpty, 1'b1);
    chk("rst_full", fifoFull, 1'b0);
    chk("rst_data", fifoData, 8'h00);
    chk("rst_pulses", {frameDone, frameErr}, 2'b00);
    chk("rst_errcnt", errCount, 8'h00);

    // 1: basic good frame
    push_b(8'hA5, 0); push_b(8'h03, 0); push_b(8'h11, 0); push_b(8'h22, 0); push_b(8'h33, 0); push_b(8'h66, 0);
    pay = '{8'h11, 8'h22, 8'h33};
    xfer(1, 1);
    chk("t1_empty", fifoEmpty, 1'b0);
    drain();

    // 2: checksum mismatch
    push_b(8'hA5, 0); push_b(8'h02, 0); push_b(8'h10, 0); push_b(8'h20, 0); push_b(8'h31, 0);
    xfer(2, 1);
    chk("t2_empty", fifoEmpty, 1'b1);

    // 3: disparity error mid-payload, then recovery
    push_b(8'hA5, 0); push_b(8'h03, 0); push_b(8'h11, 0); push_b(8'h22, 3'b001);
    xfer(2, 1);
    push_b(8'hA5, 0); push_b(8'h01, 0); push_b(8'h7F, 0); push_b(8'h7F, 0);
    pay = '{8'h7F};
    xfer(1, 1);
    drain();

    // 4: fill to full, overflow abort, readback intact
    push_frame(16, 16, 1);
    xfer(1, 1);
    chk("t4_full", fifoFull, 1'b1);
    push_b(8'hA5, 0); push_b(8'h01, 0); push_b(8'h05, 0);
    xfer(2, 1);
    chk("t4_full_kept", fifoFull, 1'b1);
    drain();
    chk("t4_not_full", fifoFull, 1'b0);

    // 5: illegal lengths; leading junk ignored
    push_b(8'hA5, 0); push_b(8'h00, 0);
    xfer(2, 1);
    push_b(8'hA5, 0); push_b(8'h11, 0);
    xfer(2, 1);
    chk("t5_empty", fifoEmpty, 1'b1);
    push_b(8'h00, 0); push_b(8'hFF, 0); push_b(8'hA5, 3'b100);
    push_b(8'hA5, 0); push_b(8'h01, 0); push_b(8'h42, 0); push_b(8'h42, 0);
    pay = '{8'h42};
    xfer(1, 1);
    drain();

    // SOF on the abort cycle is dropped, so the rest is junk
    push_b(8'hA5, 0); push_b(8'h00, 0);
    xfer(2, 0);
    push_b(8'hA5, 0); push_b(8'h01, 0); push_b(8'h7F, 0); push_b(8'h7F, 0);
    xfer(0, 1);
    chk("abort_sof_empty", fifoEmpty, 1'b1);

    // 6: reset during payload with committed data pending
    push_b(8'hA5, 0); push_b(8'h01, 0); push_b(8'h55, 0); push_b(8'h55, 0);
    pay = '{8'h55};
    xfer(1, 1);
    push_b(8'hA5, 0); push_b(8'h04, 0); push_b(8'h01, 0); push_b(8'h02, 0);
    xfer(0, 0);
    do_reset();
    mq.delete();
    aborts = 0;
    chk("t6_empty", fifoEmpty, 1'b1);
    chk("t6_full", fifoFull, 1'b0);
    chk("t6_errcnt", errCount, 8'h00);
    chk("t6_pulses", {frameDone, frameErr}, 2'b00);
    push_b(8'hA5, 0); push_b(8'h02, 0); push_b(8'h01, 0); push_b(8'h02, 0); push_b(8'h03, 0);
    pay = '{8'h01, 8'h02};
    xfer(1, 1);
    drain();

    // randomized frames with gaps and interleaved reads
    rand_gap = 1'b1;
    for (int f = 0; f < 60; f++) begin
      pop_n($urandom_range(0, mq.size()));
      room = DEPTH - mq.size();
      kind = $urandom_range(0, 4);
      len  = $urandom_range(1, MAXL);
      case (kind)
        1: begin
          if (len <= room) push_frame(len, len, 2);
          else             push_frame(len, room + 1, 0);
          xfer(2, 1);
        end
        2: begin
          j = $urandom_range(0, (len < room) ? len : room);
          push_frame(len, j, 0);
          push_b(8'($urandom), 3'($urandom_range(1, 7)));
          xfer(2, 1);
        end
        3: begin
          push_b(SOF, 0);
          push_b(($urandom % 2) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)), 0);
          xfer(2, 1);
        end
        default: begin
          if (kind == 4) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
              gb = 8'($urandom);
              push_b(gb, (gb == SOF) ? 3'($urandom_range(1, 7)) : 3'($urandom));
            end
          end
          if (len <= room) begin
            logic [7:0] pre_b[$];
            logic [2:0] pre_f[$];
            pre_b = tx_b; pre_f = tx_f;
            push_frame(len, len, 1);
            tx_b = {pre_b, tx_b[0:$]};
            tx_f = {pre_f, tx_f[0:$]};
            xfer(1, 1);
          end else begin
            tx_b.delete(); tx_f.delete();
            push_frame(len, room + 1, 0);
            xfer(2, 1);
          end
        end
      endcase
    end
    drain();
    chk("final_full", fifoFull, 1'b0);
    chk("final_errcnt", errCount, exp_ec());

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
